// File: rtl/occ_pkg.sv
// Shared types and helpers for the occupancy monitor.
// Channel FSM encoding and a small popcount used for the occupied count.
package occ_pkg;

    typedef enum logic [1:0] {
        CH_FREE,
        CH_BUSY,
        CH_OVERTIME
    } ch_state_e;

    function automatic logic [3:0] popcount(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/sw_debounce.sv
// Single-channel switch debouncer: a new level is accepted only after
// DEB_CYCLES consecutive samples that differ from the current stable level.
module sw_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk_2,
    input  logic reset,
    input  logic i_raw,
    output logic o_stable
);

    localparam int DW = $clog2(DEB_CYCLES + 1);

    logic          r_stable;
    logic [DW-1:0] r_cnt;
    logic          w_diff;
    logic          w_last;

    assign w_diff = (i_raw != r_stable);
    assign w_last = (r_cnt == DW'(DEB_CYCLES - 1));

    always_ff @(posedge clk_2) begin
        if (reset) begin
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else if (!w_diff) begin
            r_cnt    <= '0;
        end else if (w_last) begin
            r_stable <= i_raw;
            r_cnt    <= '0;
        end else begin
            r_cnt    <= r_cnt + 1'b1;
        end
    end

    assign o_stable = r_stable;

endmodule

// File: rtl/occupancy_monitor.sv
// Per-channel debounce, occupancy timers with overtime detection,
// group-free status, occupied count and a blinking overtime alarm.
module occupancy_monitor
    import occ_pkg::*;
#(
    parameter int              NCH          = 3,
    parameter int              DEB_CYCLES   = 4,
    parameter int              TIMEOUT      = 16,
    parameter int              BLINK_CYCLES = 8,
    parameter logic [NCH-1:0]  MASK_A       = 3'b111,
    parameter logic [NCH-1:0]  MASK_B       = 3'b110
) (
    input  logic                       clk_2,
    input  logic                       reset,
    input  logic [NCH-1:0]             occ_i,
    input  logic                       ack_i,
    output logic [NCH-1:0]             stable_o,
    output logic [NCH-1:0]             overtime_o,
    output logic                       free_a_o,
    output logic                       free_b_o,
    output logic [$clog2(NCH+1)-1:0]   count_o,
    output logic                       alarm_o
);

    localparam int CW = $clog2(NCH + 1);
    localparam int TW = $clog2(TIMEOUT);
    localparam int BW = $clog2(BLINK_CYCLES + 1);

    logic [NCH-1:0] w_stable;
    ch_state_e      r_state   [NCH];
    ch_state_e      w_state_nx[NCH];
    logic [TW-1:0]  r_timer   [NCH];
    logic [TW-1:0]  w_timer_nx[NCH];
    logic [TW-1:0]  w_timer_inc[NCH];
    logic [NCH-1:0] w_ot_nx;
    logic [NCH-1:0] r_ot;
    logic           r_free_a;
    logic           r_free_b;
    logic [CW-1:0]  r_count;
    logic [BW-1:0]  r_blink;
    logic           r_alarm;
    logic [7:0]     w_st8;
    logic [3:0]     w_pop;

    for (genvar g = 0; g < NCH; g++) begin : g_deb
        sw_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .clk_2   (clk_2),
            .reset   (reset),
            .i_raw   (occ_i[g]),
            .o_stable(w_stable[g])
        );
    end

    always_ff @(posedge clk_2) begin
        for (int i = 0; i < NCH; i++) begin
            if (reset) begin
                r_state[i] <= CH_FREE;
                r_timer[i] <= '0;
            end else begin
                r_state[i] <= w_state_nx[i];
                r_timer[i] <= w_timer_nx[i];
            end
        end
    end

    // Overtime is entered on the edge where the incremented timer reaches
    // TIMEOUT-1, so overtime_o rises TIMEOUT edges after stable_o.
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            w_state_nx[i]  = r_state[i];
            w_timer_nx[i]  = r_timer[i];
            w_timer_inc[i] = r_timer[i] + 1'b1;
            unique case (r_state[i])
                CH_FREE: begin
                    if (w_stable[i]) begin
                        w_state_nx[i] = CH_BUSY;
                        w_timer_nx[i] = '0;
                    end
                end
                CH_BUSY: begin
                    if (!w_stable[i]) begin
                        w_state_nx[i] = CH_FREE;
                    end else begin
                        w_timer_nx[i] = w_timer_inc[i];
                        if (w_timer_inc[i] == TW'(TIMEOUT - 1)) begin
                            w_state_nx[i] = CH_OVERTIME;
                        end
                    end
                end
                CH_OVERTIME: begin
                    if (!w_stable[i]) begin
                        w_state_nx[i] = CH_FREE;
                    end else if (ack_i) begin
                        w_state_nx[i] = CH_BUSY;
                        w_timer_nx[i] = '0;
                    end
                end
                default: begin
                    w_state_nx[i] = CH_FREE;
                    w_timer_nx[i] = '0;
                end
            endcase
            w_ot_nx[i] = (w_state_nx[i] == CH_OVERTIME);
        end
    end

    assign w_st8 = 8'(w_stable);
    assign w_pop = popcount(w_st8);

    always_ff @(posedge clk_2) begin
        if (reset) begin
            r_ot     <= '0;
            r_free_a <= (MASK_A != '0);
            r_free_b <= (MASK_B != '0);
            r_count  <= '0;
        end else begin
            r_ot     <= w_ot_nx;
            r_free_a <= ~&(w_stable | ~MASK_A);
            r_free_b <= ~&(w_stable | ~MASK_B);
            r_count  <= CW'(w_pop);
        end
    end

    // Clear on the same edge the last overtime ends; count only once
    // overtime_o is visible so the first toggle lands BLINK_CYCLES later.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            r_blink <= '0;
            r_alarm <= 1'b0;
        end else if (!(|w_ot_nx)) begin
            r_blink <= '0;
            r_alarm <= 1'b0;
        end else if (|r_ot) begin
            if (r_blink == BW'(BLINK_CYCLES - 1)) begin
                r_blink <= '0;
                r_alarm <= ~r_alarm;
            end else begin
                r_blink <= r_blink + 1'b1;
            end
        end
    end

    assign stable_o   = w_stable;
    assign overtime_o = r_ot;
    assign free_a_o   = r_free_a;
    assign free_b_o   = r_free_b;
    assign count_o    = r_count;
    assign alarm_o    = r_alarm;

endmodule

// File: tb/tb_occupancy_monitor.sv
// Directed bench for occupancy_monitor at default parameters.
// Outputs are sampled 1 time unit after each rising edge.
module tb_occupancy_monitor;

    logic       clk_2 = 1'b0;
    logic       reset;
    logic [2:0] occ_i;
    logic       ack_i;
    logic [2:0] stable_o;
    logic [2:0] overtime_o;
    logic       free_a_o;
    logic       free_b_o;
    logic [1:0] count_o;
    logic       alarm_o;

    int n_chk  = 0;
    int n_fail = 0;

    occupancy_monitor dut (
        .clk_2     (clk_2),
        .reset     (reset),
        .occ_i     (occ_i),
        .ack_i     (ack_i),
        .stable_o  (stable_o),
        .overtime_o(overtime_o),
        .free_a_o  (free_a_o),
        .free_b_o  (free_b_o),
        .count_o   (count_o),
        .alarm_o   (alarm_o)
    );

    always #5 clk_2 = ~clk_2;

    task automatic tick(input int n);
        repeat (n) @(posedge clk_2);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        occ_i = 3'b000;
        ack_i = 1'b0;
        tick(1);
        reset = 1'b0;
    endtask

    task automatic chk_rst_vals(input string tag);
        n_chk++;
        if (stable_o !== 3'b000 || overtime_o !== 3'b000 || count_o !== 2'd0 ||
            alarm_o !== 1'b0 || free_a_o !== 1'b1 || free_b_o !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: stable=%b ot=%b cnt=%0d alarm=%b fa=%b fb=%b, want 000 000 0 0 1 1",
                     tag, stable_o, overtime_o, count_o, alarm_o, free_a_o, free_b_o);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        occ_i = 3'b000;
        ack_i = 1'b0;
        tick(2);
        chk_rst_vals("reset_state");
        reset = 1'b0;
    endtask

    task automatic test_debounce();
        do_reset();
        occ_i = 3'b001;
        tick(3);
        n_chk++;
        if (stable_o !== 3'b000) begin
            n_fail++;
            $display("FAIL deb_early: stable=%b want 000", stable_o);
        end
        tick(1);
        n_chk++;
        if (stable_o !== 3'b001 || count_o !== 2'd0) begin
            n_fail++;
            $display("FAIL deb_rise: stable=%b cnt=%0d want 001 0", stable_o, count_o);
        end
        tick(1);
        n_chk++;
        if (count_o !== 2'd1 || free_a_o !== 1'b1 || free_b_o !== 1'b1) begin
            n_fail++;
            $display("FAIL deb_count: cnt=%0d fa=%b fb=%b want 1 1 1",
                     count_o, free_a_o, free_b_o);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        occ_i = 3'b001;
        tick(3);
        occ_i = 3'b000;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            n_chk++;
            if (stable_o !== 3'b000 || count_o !== 2'd0 || overtime_o !== 3'b000) begin
                n_fail++;
                $display("FAIL glitch_c%0d: stable=%b cnt=%0d ot=%b want 000 0 000",
                         i, stable_o, count_o, overtime_o);
            end
        end
    endtask

    task automatic test_groups();
        do_reset();
        occ_i = 3'b110;
        tick(4);
        n_chk++;
        if (stable_o !== 3'b110) begin
            n_fail++;
            $display("FAIL grp_stable: stable=%b want 110", stable_o);
        end
        tick(1);
        n_chk++;
        if (free_b_o !== 1'b0 || free_a_o !== 1'b1 || count_o !== 2'd2) begin
            n_fail++;
            $display("FAIL grp_110: fa=%b fb=%b cnt=%0d want 1 0 2",
                     free_a_o, free_b_o, count_o);
        end
        occ_i = 3'b111;
        tick(4);
        n_chk++;
        if (stable_o !== 3'b111 || count_o !== 2'd2) begin
            n_fail++;
            $display("FAIL grp_111_lat: stable=%b cnt=%0d want 111 2", stable_o, count_o);
        end
        tick(1);
        n_chk++;
        if (free_a_o !== 1'b0 || free_b_o !== 1'b0 || count_o !== 2'd3) begin
            n_fail++;
            $display("FAIL grp_111: fa=%b fb=%b cnt=%0d want 0 0 3",
                     free_a_o, free_b_o, count_o);
        end
    endtask

    task automatic test_overtime_alarm();
        do_reset();
        occ_i = 3'b001;
        tick(19);
        n_chk++;
        if (overtime_o !== 3'b000) begin
            n_fail++;
            $display("FAIL ot_early: ot=%b want 000", overtime_o);
        end
        tick(1);
        n_chk++;
        if (overtime_o !== 3'b001 || alarm_o !== 1'b0) begin
            n_fail++;
            $display("FAIL ot_rise: ot=%b alarm=%b want 001 0", overtime_o, alarm_o);
        end
        tick(7);
        n_chk++;
        if (alarm_o !== 1'b0) begin
            n_fail++;
            $display("FAIL alarm_early: alarm=%b want 0", alarm_o);
        end
        tick(1);
        n_chk++;
        if (alarm_o !== 1'b1) begin
            n_fail++;
            $display("FAIL alarm_on1: alarm=%b want 1", alarm_o);
        end
        tick(7);
        n_chk++;
        if (alarm_o !== 1'b1) begin
            n_fail++;
            $display("FAIL alarm_hold: alarm=%b want 1", alarm_o);
        end
        tick(1);
        n_chk++;
        if (alarm_o !== 1'b0) begin
            n_fail++;
            $display("FAIL alarm_off: alarm=%b want 0", alarm_o);
        end
        tick(8);
        n_chk++;
        if (alarm_o !== 1'b1) begin
            n_fail++;
            $display("FAIL alarm_on2: alarm=%b want 1", alarm_o);
        end
        ack_i = 1'b1;
        tick(1);
        ack_i = 1'b0;
        n_chk++;
        if (overtime_o !== 3'b000 || alarm_o !== 1'b0) begin
            n_fail++;
            $display("FAIL ack: ot=%b alarm=%b want 000 0", overtime_o, alarm_o);
        end
        tick(14);
        n_chk++;
        if (overtime_o !== 3'b000) begin
            n_fail++;
            $display("FAIL reot_early: ot=%b want 000", overtime_o);
        end
        tick(1);
        n_chk++;
        if (overtime_o !== 3'b001) begin
            n_fail++;
            $display("FAIL reot: ot=%b want 001", overtime_o);
        end
    endtask

    task automatic test_release_vs_ack();
        occ_i = 3'b000;
        tick(4);
        n_chk++;
        if (stable_o !== 3'b000 || overtime_o !== 3'b001) begin
            n_fail++;
            $display("FAIL rel_pre: stable=%b ot=%b want 000 001", stable_o, overtime_o);
        end
        ack_i = 1'b1;
        tick(1);
        ack_i = 1'b0;
        n_chk++;
        if (overtime_o !== 3'b000 || alarm_o !== 1'b0 || count_o !== 2'd0) begin
            n_fail++;
            $display("FAIL rel_ack: ot=%b alarm=%b cnt=%0d want 000 0 0",
                     overtime_o, alarm_o, count_o);
        end
        tick(20);
        n_chk++;
        if (overtime_o !== 3'b000 || stable_o !== 3'b000) begin
            n_fail++;
            $display("FAIL rel_idle: ot=%b stable=%b want 000 000", overtime_o, stable_o);
        end
    endtask

    task automatic test_reset_mid_alarm();
        do_reset();
        occ_i = 3'b001;
        tick(28);
        n_chk++;
        if (overtime_o !== 3'b001 || alarm_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre: ot=%b alarm=%b want 001 1", overtime_o, alarm_o);
        end
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        chk_rst_vals("rst_mid_alarm");
        tick(3);
        n_chk++;
        if (stable_o !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_deb_early: stable=%b want 000", stable_o);
        end
        tick(1);
        n_chk++;
        if (stable_o !== 3'b001) begin
            n_fail++;
            $display("FAIL rst_deb_rise: stable=%b want 001", stable_o);
        end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_glitch();
        test_groups();
        test_overtime_alarm();
        test_release_vs_ack();
        test_reset_mid_alarm();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
